// File: rtl/ace_ccu_conflict_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ace_ccu_conflict_tracker
// Brief    : Reference-counted table of in-flight line indices; stalls snoops
//            that hit a tracked line. Optional statistics are enabled by
//            defining ACE_CCU_CONFLICT_TRACKER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ace_ccu_conflict_tracker #(
  parameter int unsigned NoRespPorts = 4,
  parameter int unsigned MaxTrans    = 8,
  parameter int unsigned CmAddrWidth = 8,
  parameter int unsigned CntWidth    = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NoRespPorts-1:0]                x_req_valid_i,
  output logic [NoRespPorts-1:0]                x_req_ready_o,
  input  logic [NoRespPorts*CmAddrWidth-1:0]    x_addr_i,
  input  logic [NoRespPorts-1:0]                x_done_i,
  input  logic [NoRespPorts*CmAddrWidth-1:0]    x_done_addr_i,
  input  logic                                  snoop_valid_i,
  input  logic [CmAddrWidth-1:0]                snoop_addr_i,
  output logic                                  snoop_stall_o,
  output logic [$clog2(MaxTrans+1)-1:0]         occupancy_o,
  output logic                                  full_o,
  output logic [31:0]                           stall_cycles_o,
  output logic [$clog2(MaxTrans+1)-1:0]         peak_occ_o
);

  localparam int unsigned OCC_W = $clog2(MaxTrans + 1);
  localparam int unsigned PTR_W = (NoRespPorts > 1) ? $clog2(NoRespPorts) : 1;
  localparam int unsigned PC_W  = $clog2(NoRespPorts + 1);
  localparam int unsigned SUM_W = CntWidth + PC_W;
  localparam logic [CntWidth-1:0] CNT_MAX = '1;

  logic [MaxTrans-1:0]                  valid_q, valid_d;
  logic [MaxTrans-1:0][CmAddrWidth-1:0] addr_q, addr_d;
  logic [MaxTrans-1:0][CntWidth-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]                     rr_q, rr_d;

  logic [NoRespPorts-1:0][CmAddrWidth-1:0] req_addr, done_addr;
  logic [PTR_W-1:0]       pidx, cand_port;
  logic                   cand_found;
  logic [CmAddrWidth-1:0] cand_addr;
  logic [MaxTrans-1:0]    hit_vec, free_oh, at_max, inc_vec, alloc_vec;
  logic                   hit, free_found, blocked, grant;
  logic [SUM_W-1:0]       rel, net;
  logic [OCC_W-1:0]       occ;

  assign req_addr  = x_addr_i;
  assign done_addr = x_done_addr_i;

  // Round-robin search for the first requesting port starting at rr_q.
  always_comb begin
    cand_found = 1'b0;
    cand_port  = '0;
    pidx       = '0;
    for (int unsigned i = 0; i < NoRespPorts; i++) begin
      pidx = PTR_W'((32'(rr_q) + i) % NoRespPorts);
      if (!cand_found && x_req_valid_i[pidx]) begin
        cand_found = 1'b1;
        cand_port  = pidx;
      end
    end
  end

  assign cand_addr = req_addr[cand_port];

  always_comb begin
    hit_vec    = '0;
    free_oh    = '0;
    at_max     = '0;
    free_found = 1'b0;
    for (int unsigned e = 0; e < MaxTrans; e++) begin
      hit_vec[e] = valid_q[e] && (addr_q[e] == cand_addr);
      at_max[e]  = (cnt_q[e] == CNT_MAX);
      if (!valid_q[e] && !free_found) begin
        free_oh[e] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  // Decisions use registered state only, so a same-cycle release never
  // unblocks a saturated hit or a miss on a full table.
  assign hit     = |hit_vec;
  assign blocked = hit ? |(hit_vec & at_max) : !free_found;
  assign grant   = cand_found && !blocked;

  assign inc_vec   = (grant && hit)  ? hit_vec : '0;
  assign alloc_vec = (grant && !hit) ? free_oh : '0;

  always_comb begin
    x_req_ready_o = '0;
    rr_d          = rr_q;
    if (grant) begin
      x_req_ready_o[cand_port] = 1'b1;
      rr_d = (cand_port == PTR_W'(NoRespPorts - 1)) ? '0 : cand_port + PTR_W'(1);
    end
  end

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rel     = '0;
    net     = '0;
    for (int unsigned e = 0; e < MaxTrans; e++) begin
      rel = '0;
      for (int unsigned p = 0; p < NoRespPorts; p++) begin
        if (x_done_i[p] && valid_q[e] && (done_addr[p] == addr_q[e])) begin
          rel = rel + SUM_W'(1);
        end
      end
      net = SUM_W'(cnt_q[e]) + SUM_W'(inc_vec[e]);
      if (alloc_vec[e]) begin
        valid_d[e] = 1'b1;
        addr_d[e]  = cand_addr;
        cnt_d[e]   = CntWidth'(1);
      end else if (valid_q[e]) begin
        if (net <= rel) begin
          valid_d[e] = 1'b0;
          cnt_d[e]   = '0;
        end else begin
          cnt_d[e]   = CntWidth'(net - rel);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned e = 0; e < MaxTrans; e++) begin
      occ = occ + OCC_W'(valid_q[e]);
    end
  end

  assign occupancy_o = occ;
  assign full_o      = (occ == OCC_W'(MaxTrans));

  always_comb begin
    snoop_stall_o = 1'b0;
    for (int unsigned e = 0; e < MaxTrans; e++) begin
      if (snoop_valid_i && valid_q[e] && (addr_q[e] == snoop_addr_i)) begin
        snoop_stall_o = 1'b1;
      end
    end
  end

`ifdef ACE_CCU_CONFLICT_TRACKER_STATS_EN
  logic [31:0]      stall_cnt_q;
  logic [OCC_W-1:0] peak_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      peak_q      <= '0;
    end else begin
      if (snoop_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (occ > peak_q) begin
        peak_q <= occ;
      end
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign peak_occ_o     = peak_q;
`else
  assign stall_cycles_o = '0;
  assign peak_occ_o     = '0;
`endif

`ifndef SYNTHESIS
  logic [NoRespPorts-1:0] done_hit;

  always_comb begin
    done_hit = '0;
    for (int unsigned p = 0; p < NoRespPorts; p++) begin
      for (int unsigned e = 0; e < MaxTrans; e++) begin
        if (valid_q[e] && (done_addr[p] == addr_q[e])) begin
          done_hit[p] = 1'b1;
        end
      end
    end
  end

  // A release must always name a line that is currently tracked.
  a_release_tracked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (x_done_i & ~done_hit) == '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ace_ccu_conflict_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ace_ccu_conflict_tracker
// Brief    : Self-checking bench for ace_ccu_conflict_tracker; expected grant
//            vectors are queued as stimulus is driven and popped on sampling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ace_ccu_conflict_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid, done;
  logic [31:0] req_addr, done_addr;
  logic        snp_v;
  logic [7:0]  snp_a;
  wire  [3:0]  req_ready;
  wire         stall, full;
  wire  [3:0]  occ, peak;
  wire  [31:0] stall_cycles;

  logic [3:0]  b_valid, b_done;
  logic [31:0] b_addr, b_done_addr;
  logic        b_snp_v;
  logic [7:0]  b_snp_a;
  wire  [3:0]  b_ready, b_occ, b_peak;
  wire         b_stall, b_full;
  wire  [31:0] b_stall_cycles;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [3:0]  exp_rdy_q[$];
  logic [3:0]  exp_rdy;

  always #5 clk = ~clk;

  ace_ccu_conflict_tracker dut (
    .clk_i(clk), .rst_ni(rst_n),
    .x_req_valid_i(req_valid), .x_req_ready_o(req_ready), .x_addr_i(req_addr),
    .x_done_i(done), .x_done_addr_i(done_addr),
    .snoop_valid_i(snp_v), .snoop_addr_i(snp_a), .snoop_stall_o(stall),
    .occupancy_o(occ), .full_o(full),
    .stall_cycles_o(stall_cycles), .peak_occ_o(peak)
  );

  ace_ccu_conflict_tracker #(.CntWidth(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .x_req_valid_i(b_valid), .x_req_ready_o(b_ready), .x_addr_i(b_addr),
    .x_done_i(b_done), .x_done_addr_i(b_done_addr),
    .snoop_valid_i(b_snp_v), .snoop_addr_i(b_snp_a), .snoop_stall_o(b_stall),
    .occupancy_o(b_occ), .full_o(b_full),
    .stall_cycles_o(b_stall_cycles), .peak_occ_o(b_peak)
  );

  task automatic idle();
    req_valid = '0; done = '0; req_addr = '0; done_addr = '0;
    snp_v = 1'b0; snp_a = '0;
    b_valid = '0; b_done = '0; b_addr = '0; b_done_addr = '0;
    b_snp_v = 1'b0; b_snp_a = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    snp_v = 1'b1;
    #3;
    n_chk++; if (occ !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occ); end
    n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_chk++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_chk++; if (stall_cycles !== 32'd0 || peak !== 4'd0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stall_cycles, peak);
    end
  endtask

  task automatic test_single_alloc();
    do_reset();
    req_valid = 4'b0001; req_addr[7:0] = 8'h12;
    snp_v = 1'b1; snp_a = 8'h12;
    exp_rdy_q.push_back(4'b0001);
    #3;
    exp_rdy = exp_rdy_q.pop_front();
    n_chk++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL single_grant: got %b expected %b", req_ready, exp_rdy); end
    n_chk++; if (occ !== 4'd0 || stall !== 1'b0) begin n_fail++; $display("FAIL single_latency: got occ=%0d stall=%b expected 0/0", occ, stall); end
    tick();
    req_valid = '0;
    #3;
    n_chk++; if (occ !== 4'd1) begin n_fail++; $display("FAIL single_occ: got %0d expected 1", occ); end
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL snoop_hit: got %b expected 1", stall); end
    snp_a = 8'h13;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL snoop_miss: got %b expected 0", stall); end
    snp_v = 1'b0; snp_a = 8'h12;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL snoop_invalid: got %b expected 0", stall); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'hF;
    req_addr = {8'h04, 8'h03, 8'h02, 8'h01};
    for (int k = 0; k < 4; k++) begin
      exp_rdy_q.push_back(4'(1 << k));
      #3;
      exp_rdy = exp_rdy_q.pop_front();
      n_chk++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, exp_rdy); end
      n_chk++; if (occ !== 4'(k)) begin n_fail++; $display("FAIL rr_occ%0d: got %0d expected %0d", k, occ, k); end
      tick();
      req_valid[k] = 1'b0;
    end
    #3;
    n_chk++; if (occ !== 4'd4) begin n_fail++; $display("FAIL rr_occ_final: got %0d expected 4", occ); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_valid = 4'b0001; req_addr[7:0] = 8'(i + 1);
      exp_rdy_q.push_back(4'b0001);
      #3;
      exp_rdy = exp_rdy_q.pop_front();
      n_chk++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL fill_grant%0d: got %b expected %b", i, req_ready, exp_rdy); end
      tick();
    end
    req_valid = '0;
    #3;
    n_chk++; if (occ !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL full_state: got occ=%0d full=%b expected 8/1", occ, full); end
    req_valid = 4'b0010; req_addr[15:8] = 8'h40;
    exp_rdy_q.push_back(4'b0000);
    #1;
    exp_rdy = exp_rdy_q.pop_front();
    n_chk++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL full_miss_block: got %b expected %b", req_ready, exp_rdy); end
    req_valid = 4'b0100; req_addr[23:16] = 8'h03;
    exp_rdy_q.push_back(4'b0100);
    #1;
    exp_rdy = exp_rdy_q.pop_front();
    n_chk++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL full_hit_grant: got %b expected %b", req_ready, exp_rdy); end
    tick();
    req_valid = 4'b0010;
    done = 4'b0001; done_addr[7:0] = 8'h05;
    exp_rdy_q.push_back(4'b0000);
    #3;
    exp_rdy = exp_rdy_q.pop_front();
    n_chk++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL free_same_cycle: got %b expected %b", req_ready, exp_rdy); end
    n_chk++; if (occ !== 4'd8) begin n_fail++; $display("FAIL full_hit_occ: got %0d expected 8", occ); end
    tick();
    done = '0;
    exp_rdy_q.push_back(4'b0010);
    #3;
    exp_rdy = exp_rdy_q.pop_front();
    n_chk++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL free_next_cycle: got %b expected %b", req_ready, exp_rdy); end
    n_chk++; if (occ !== 4'd7 || full !== 1'b0) begin n_fail++; $display("FAIL after_free: got occ=%0d full=%b expected 7/0", occ, full); end
    tick();
    req_valid = '0;
    snp_v = 1'b1; snp_a = 8'h40;
    #3;
    n_chk++; if (stall !== 1'b1 || occ !== 4'd8) begin n_fail++; $display("FAIL new_line: got stall=%b occ=%0d expected 1/8", stall, occ); end
    snp_a = 8'h05;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL freed_line: got %b expected 0", stall); end
    snp_a = 8'h03;
    done = 4'b1000; done_addr[31:24] = 8'h03;
    tick();
    done = '0;
    #1;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL cnt2_first_release: got %b expected 1", stall); end
    done = 4'b1000;
    tick();
    done = '0;
    #1;
    n_chk++; if (stall !== 1'b0 || occ !== 4'd7) begin n_fail++; $display("FAIL cnt2_second_release: got stall=%b occ=%0d expected 0/7", stall, occ); end
  endtask

  task automatic test_multi_release();
    do_reset();
    req_valid = 4'b0001; req_addr[7:0] = 8'h20;
    for (int i = 0; i < 3; i++) begin
      exp_rdy_q.push_back(4'b0001);
      #3;
      exp_rdy = exp_rdy_q.pop_front();
      n_chk++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL multi_grant%0d: got %b expected %b", i, req_ready, exp_rdy); end
      tick();
    end
    req_valid = '0;
    done = 4'b0101; done_addr = {8'h00, 8'h20, 8'h00, 8'h20};
    tick();
    done = '0;
    snp_v = 1'b1; snp_a = 8'h20;
    #1;
    n_chk++; if (stall !== 1'b1 || occ !== 4'd1) begin n_fail++; $display("FAIL dual_release: got stall=%b occ=%0d expected 1/1", stall, occ); end
    done = 4'b0010; done_addr[15:8] = 8'h20;
    tick();
    done = '0;
    #1;
    n_chk++; if (stall !== 1'b0 || occ !== 4'd0) begin n_fail++; $display("FAIL last_release: got stall=%b occ=%0d expected 0/0", stall, occ); end
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0001;
    done = 4'b1000; done_addr[31:24] = 8'h20;
    exp_rdy_q.push_back(4'b0010);
    exp_rdy_q.push_back(4'b0001);
    exp_rdy = exp_rdy_q.pop_front();
    exp_rdy = exp_rdy_q.pop_front();
    #1;
    n_chk++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL same_cycle_grant: got %b expected %b", req_ready, exp_rdy); end
    tick();
    req_valid = '0; done = '0;
    #1;
    n_chk++; if (stall !== 1'b1 || occ !== 4'd1) begin n_fail++; $display("FAIL same_cycle_net: got stall=%b occ=%0d expected 1/1", stall, occ); end
  endtask

  task automatic test_saturation();
    do_reset();
    b_valid = 4'b0001; b_addr[7:0] = 8'h30;
    for (int i = 0; i < 3; i++) begin
      exp_rdy_q.push_back(4'b0001);
      #3;
      exp_rdy = exp_rdy_q.pop_front();
      n_chk++; if (b_ready !== exp_rdy) begin n_fail++; $display("FAIL sat_grant%0d: got %b expected %b", i, b_ready, exp_rdy); end
      tick();
    end
    b_done = 4'b0001; b_done_addr[7:0] = 8'h30;
    exp_rdy_q.push_back(4'b0000);
    #3;
    exp_rdy = exp_rdy_q.pop_front();
    n_chk++; if (b_ready !== exp_rdy) begin n_fail++; $display("FAIL sat_block: got %b expected %b", b_ready, exp_rdy); end
    tick();
    b_done = '0;
    exp_rdy_q.push_back(4'b0001);
    #3;
    exp_rdy = exp_rdy_q.pop_front();
    n_chk++; if (b_ready !== exp_rdy) begin n_fail++; $display("FAIL sat_unblock: got %b expected %b", b_ready, exp_rdy); end
    tick();
    b_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      req_addr[7:0] = 8'(8'h51 + i);
      tick();
    end
    req_valid = '0;
    snp_v = 1'b1; snp_a = 8'h51;
    #1;
    n_chk++; if (occ !== 4'd5) begin n_fail++; $display("FAIL mid_occ: got %0d expected 5", occ); end
    tick(); tick(); tick();
`ifdef ACE_CCU_CONFLICT_TRACKER_STATS_EN
    n_chk++; if (stall_cycles !== 32'd3 || peak !== 4'd5) begin
      n_fail++; $display("FAIL stats_count: got %0d/%0d expected 3/5", stall_cycles, peak);
    end
`else
    n_chk++; if (stall_cycles !== 32'd0 || peak !== 4'd0) begin
      n_fail++; $display("FAIL stats_tied: got %0d/%0d expected 0/0", stall_cycles, peak);
    end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (occ !== 4'd0 || stall !== 1'b0 || full !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got occ=%0d stall=%b full=%b expected 0/0/0", occ, stall, full);
    end
    n_chk++; if (stall_cycles !== 32'd0 || peak !== 4'd0) begin
      n_fail++; $display("FAIL reset_stats_clear: got %0d/%0d expected 0/0", stall_cycles, peak);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    n_chk++; if (stall !== 1'b0 || occ !== 4'd0) begin n_fail++; $display("FAIL post_reset: got stall=%b occ=%0d expected 0/0", stall, occ); end
  endtask

  initial begin
    test_reset();
    test_single_alloc();
    test_round_robin();
    test_full();
    test_multi_release();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ace_ccu_conflict_tracker.md
Name: ace_ccu_conflict_tracker

Overview:
Parametrised successor to the CCU conflict manager. Tracks cache-line indices that have in-flight master-path transactions in a fully associative, reference-counted table. Stalls the snoop interconnect when a snoop targets a tracked line. Supports N arbitrated allocation ports, multi-port release per cycle, counter saturation back-pressure and optional statistics; sits between ace_ccu_master_path and ace_ccu_snoop_interconnect.

Parameters:
NoRespPorts, 4, number of allocate/release port pairs (>=1)
MaxTrans, 8, table entries (distinct outstanding lines, >=2)
CmAddrWidth, 8, line-index width
CntWidth, 4, per-entry reference counter width; max count 2**CntWidth-1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
x_req_valid_i  in  NoRespPorts  allocate request per port
x_req_ready_o  out  NoRespPorts  allocate grant; transfer on valid&&ready
x_addr_i  in  NoRespPorts*CmAddrWidth  line index per allocate port
x_done_i  in  NoRespPorts  single-cycle release pulse per port
x_done_addr_i  in  NoRespPorts*CmAddrWidth  line index being released
snoop_valid_i  in  1  snoop lookup valid
snoop_addr_i  in  CmAddrWidth  snoop line index
snoop_stall_o  out  1  snoop must not proceed this cycle
occupancy_o  out  $clog2(MaxTrans+1)  valid entries
full_o  out  1  all entries valid
stall_cycles_o  out  32  stats (optional feature)
peak_occ_o  out  $clog2(MaxTrans+1)  stats (optional feature)

Behaviour:
- Entry = {valid, addr, cnt}. Reset: all entries invalid, cnt 0; x_req_ready_o=0, snoop_stall_o=0, occupancy_o=0, full_o=0, stats 0.
- Allocation: one grant per cycle, round-robin over ports with valid; pointer advances to granted port+1 on a transfer, holds otherwise. ready is combinational from valid; non-granted ports see ready=0 and must hold valid/addr.
- Granted addr hits a valid entry: cnt+1. Miss: lowest-index free entry gets valid=1, addr, cnt=1.
- Grant suppressed (ready=0 for all) if: miss and table full, or hit with cnt at max. A full table does not block hits.
- Release: each x_done_i decrements the matching entry; several ports may hit the same entry in one cycle, so cnt -= popcount of matching pulses. Entry reaching cnt 0 becomes invalid in the same update. Release to an untracked addr is ignored (simulation assertion fires).
- Same-cycle allocate and release on one line: net update cnt + 1 - k. Entry is not freed if net >0. A release-induced free is not usable by a miss in that same cycle.
- All table updates take effect at the next clock edge. Stall/occupancy reflect registered state, 1-cycle latency from allocation.
- snoop_stall_o = snoop_valid_i && (addr matches any valid entry). Combinational, no snoop-side state. 0 when snoop_valid_i=0.
- full_o = occupancy_o==MaxTrans, registered-derived.
- Reset asserted mid-operation clears the table immediately (async). Outstanding releases after reset are ignored.

Optional Feature:
ACE_CCU_CONFLICT_TRACKER_STATS_EN
- Defined: stall_cycles_o counts cycles with snoop_stall_o=1 (saturates at 2**32-1). peak_occ_o is the max occupancy since reset.
- Undefined: both outputs tied 0, no counter flops.

Test Plan:
- Port0 allocate 0x12 -> ready same cycle; next cycle occupancy=1. Snoop 0x12 stalls, snoop 0x13 does not.
- Ports 0-3 valid together, distinct addrs 0x01..0x04 -> grants in order 0,1,2,3 on consecutive cycles; occupancy reaches 4.
- Fill 8 distinct lines, then port1 requests new 0x40 -> ready=0, full_o=1. Port2 requests existing 0x03 -> granted, cnt=2. Release one line -> 0x40 granted the cycle after the free.
- Allocate 0x20 three times, then x_done on ports 0 and 2 for 0x20 in one cycle -> cnt=1, entry still valid. One more release -> entry freed, snoop 0x20 no longer stalls.
- CntWidth=2: allocate 0x30 three times -> fourth request ready=0 until a release.
- Reset asserted with 5 entries valid -> occupancy_o=0, snoop_stall_o=0 immediately. With the macro defined, stall_cycles_o=0 and peak_occ_o=0 after reset.
